// File: rtl/dmem_lsu.sv
// Load/store unit: turns RISC-V hart loads/stores into word-aligned, byte-masked memory requests.
// Define DMEM_LSU_TIMEOUT_EN to trap with a bus-timeout cause when memory never completes.
module dmem_lsu #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CW             = 5
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_wen,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_trap,
    output logic [1:0]  o_rsp_cause,
    output logic [31:0] o_dmem_addr,
    output logic        o_dmem_ren,
    output logic        o_dmem_wen,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_mask,
    input  logic        i_dmem_ready,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_FUNCT3  = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

    state_t      state_q;
    state_t      state_d;

    logic        wen_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [31:0] rsp_rdata_q;
    logic        rsp_trap_q;
    logic [1:0]  rsp_cause_q;

    logic        accept;
    logic        funct3_legal;
    logic        misaligned;
    logic [1:0]  req_cause;
    logic        complete;
    logic        timeout;
    logic [31:0] rdata_shifted;
    logic [31:0] load_result;

    // Request classification is done on the live request so traps skip memory entirely.
    always_comb begin
        funct3_legal = 1'b0;
        if (i_req_wen) begin
            funct3_legal = (i_req_funct3 == 3'b000) || (i_req_funct3 == 3'b001) ||
                           (i_req_funct3 == 3'b010);
        end else begin
            funct3_legal = (i_req_funct3 == 3'b000) || (i_req_funct3 == 3'b001) ||
                           (i_req_funct3 == 3'b010) || (i_req_funct3 == 3'b100) ||
                           (i_req_funct3 == 3'b101);
        end
        misaligned = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
                     ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
        if (!funct3_legal) begin
            req_cause = CAUSE_FUNCT3;
        end else if (misaligned) begin
            req_cause = CAUSE_MISALIGN;
        end else begin
            req_cause = CAUSE_NONE;
        end
    end

    assign accept   = i_req_valid && (state_q == IDLE);
    assign complete = ((state_q == REQ) && i_dmem_ready && i_dmem_rvalid) ||
                      ((state_q == WAIT) && i_dmem_rvalid);

`ifdef DMEM_LSU_TIMEOUT_EN
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    // Counts cycles spent in WAIT; a completion arriving on the last cycle still wins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if (state_q == WAIT) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end

    assign timeout = (state_q == WAIT) && !i_dmem_rvalid && (cnt_q == TIMEOUT_LAST);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (req_cause != CAUSE_NONE) ? RESP : REQ;
                end
            end
            REQ: begin
                if (i_dmem_ready) begin
                    state_d = i_dmem_rvalid ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (complete || timeout) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wen_q    <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else if (accept) begin
            wen_q    <= i_req_wen;
            funct3_q <= i_req_funct3;
            addr_q   <= i_req_addr;
            wdata_q  <= i_req_wdata;
        end
    end

    always_comb begin
        rdata_shifted = i_dmem_rdata >> {addr_q[1:0], 3'b000};
        load_result   = '0;
        if (!wen_q) begin
            case (funct3_q)
                3'b000:  load_result = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
                3'b001:  load_result = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
                3'b010:  load_result = rdata_shifted;
                3'b100:  load_result = {24'd0, rdata_shifted[7:0]};
                3'b101:  load_result = {16'd0, rdata_shifted[15:0]};
                default: load_result = '0;
            endcase
        end
    end

    // Response fields are loaded once per access and then held for the whole of RESP.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rsp_rdata_q <= '0;
            rsp_trap_q  <= 1'b0;
            rsp_cause_q <= CAUSE_NONE;
        end else if (accept && (req_cause != CAUSE_NONE)) begin
            rsp_rdata_q <= '0;
            rsp_trap_q  <= 1'b1;
            rsp_cause_q <= req_cause;
        end else if (complete) begin
            rsp_rdata_q <= load_result;
            rsp_trap_q  <= 1'b0;
            rsp_cause_q <= CAUSE_NONE;
        end else if (timeout) begin
            rsp_rdata_q <= '0;
            rsp_trap_q  <= 1'b1;
            rsp_cause_q <= CAUSE_TIMEOUT;
        end
    end

    always_comb begin
        o_dmem_mask = 4'b1111;
        case (funct3_q[1:0])
            2'b00:   o_dmem_mask = 4'b0001 << addr_q[1:0];
            2'b01:   o_dmem_mask = addr_q[1] ? 4'b1100 : 4'b0011;
            default: o_dmem_mask = 4'b1111;
        endcase
    end

    assign o_req_ready  = i_rst_n && (state_q == IDLE);
    assign o_dmem_addr  = {addr_q[31:2], 2'b00};
    assign o_dmem_wdata = wdata_q << {addr_q[1:0], 3'b000};
    assign o_dmem_ren   = (state_q == REQ) && !wen_q;
    assign o_dmem_wen   = (state_q == REQ) && wen_q;
    assign o_rsp_valid  = (state_q == RESP);
    assign o_rsp_rdata  = rsp_rdata_q;
    assign o_rsp_trap   = rsp_trap_q;
    assign o_rsp_cause  = rsp_cause_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed corner cases plus randomized accesses
// against a byte-level memory/ISA model (timeout checks depend on DMEM_LSU_TIMEOUT_EN).
module tb_dmem_lsu;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_wen;
    logic [2:0]  i_req_funct3;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_trap;
    logic [1:0]  o_rsp_cause;
    logic [31:0] o_dmem_addr;
    logic        o_dmem_ren;
    logic        o_dmem_wen;
    logic [31:0] o_dmem_wdata;
    logic [3:0]  o_dmem_mask;
    logic        i_dmem_ready;
    logic        i_dmem_rvalid;
    logic [31:0] i_dmem_rdata;

    int checks;
    int failures;

    logic [31:0] mem [int unsigned];

    dmem_lsu #(
        .TIMEOUT_CYCLES(4),
        .CW(5)
    ) dut (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .i_req_valid(i_req_valid),
        .o_req_ready(o_req_ready),
        .i_req_wen(i_req_wen),
        .i_req_funct3(i_req_funct3),
        .i_req_addr(i_req_addr),
        .i_req_wdata(i_req_wdata),
        .o_rsp_valid(o_rsp_valid),
        .i_rsp_ready(i_rsp_ready),
        .o_rsp_rdata(o_rsp_rdata),
        .o_rsp_trap(o_rsp_trap),
        .o_rsp_cause(o_rsp_cause),
        .o_dmem_addr(o_dmem_addr),
        .o_dmem_ren(o_dmem_ren),
        .o_dmem_wen(o_dmem_wen),
        .o_dmem_wdata(o_dmem_wdata),
        .o_dmem_mask(o_dmem_mask),
        .i_dmem_ready(i_dmem_ready),
        .i_dmem_rvalid(i_dmem_rvalid),
        .i_dmem_rdata(i_dmem_rdata)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        int unsigned idx;
        idx = a >> 2;
        if (!mem.exists(idx)) mem[idx] = $urandom;
        return mem[idx];
    endfunction

    // Trap cause from the ISA rules: illegal width/sign beats alignment.
    function automatic logic [1:0] model_cause(input logic wen, input logic [2:0] f3, input logic [31:0] a);
        int nbytes;
        bit legal;
        if (wen) legal = (f3 <= 3'd2);
        else     legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        if (!legal) return 2'b10;
        nbytes = 1 << f3[1:0];
        if ((a % nbytes) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [3:0] model_mask(input logic [2:0] f3, input logic [31:0] a);
        int nbytes;
        nbytes = 1 << f3[1:0];
        return 4'(((1 << nbytes) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] word, input logic [31:0] a);
        longint v;
        v = longint'(word) >> (8 * (a % 4));
        case (f3)
            3'd0: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
            3'd1: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
            3'd4: v = v % 256;
            3'd5: v = v % 65536;
            default: v = v % 64'h1_0000_0000;
        endcase
        return 32'(v);
    endfunction

    task automatic apply_stimulus(input logic wen, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        i_req_valid  = 1'b1;
        i_req_wen    = wen;
        i_req_funct3 = f3;
        i_req_addr   = a;
        i_req_wdata  = wd;
        @(negedge i_clk);
        i_req_valid  = 1'b0;
        i_req_wen    = 1'($urandom);
        i_req_funct3 = 3'($urandom);
        i_req_addr   = $urandom;
        i_req_wdata  = $urandom;
    endtask

    task automatic check_dmem(input string tag, input logic wen, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        check({tag, "_ren"}, 32'(o_dmem_ren), 32'(!wen));
        check({tag, "_wen"}, 32'(o_dmem_wen), 32'(wen));
        check({tag, "_addr"}, o_dmem_addr, a - (a % 4));
        check({tag, "_mask"}, 32'(o_dmem_mask), 32'(model_mask(f3, a)));
        check({tag, "_wdata"}, o_dmem_wdata, 32'(longint'(wd) << (8 * (a % 4))));
        check({tag, "_novalid"}, 32'(o_rsp_valid), 32'd0);
    endtask

    task automatic finish_rsp(input string tag, input logic [31:0] rdata, input logic trap, input logic [1:0] cause);
        check({tag, "_rsp_valid"}, 32'(o_rsp_valid), 32'd1);
        check({tag, "_rsp_rdata"}, o_rsp_rdata, rdata);
        check({tag, "_rsp_trap"}, 32'(o_rsp_trap), 32'(trap));
        check({tag, "_rsp_cause"}, 32'(o_rsp_cause), 32'(cause));
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata  = $urandom;
        @(negedge i_clk);
        i_dmem_rvalid = 1'b0;
        check({tag, "_hold_valid"}, 32'(o_rsp_valid), 32'd1);
        check({tag, "_hold_rdata"}, o_rsp_rdata, rdata);
        check({tag, "_hold_cause"}, 32'(o_rsp_cause), 32'(cause));
        i_rsp_ready = 1'b1;
        @(negedge i_clk);
        i_rsp_ready = 1'b0;
        check({tag, "_done_valid"}, 32'(o_rsp_valid), 32'd0);
        check({tag, "_done_ready"}, 32'(o_req_ready), 32'd1);
    endtask

    // One complete hart access with configurable memory handshake delays.
    task automatic check_output(input string tag, input logic wen, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input int ready_delay, input int rvalid_delay);
        logic [1:0]  cause;
        logic [31:0] word;
        logic [31:0] shifted;
        logic [3:0]  mask;
        cause = model_cause(wen, f3, a);
        check({tag, "_req_ready"}, 32'(o_req_ready), 32'd1);
        apply_stimulus(wen, f3, a, wd);
        if (cause != 2'b00) begin
            check({tag, "_trap_noren"}, 32'(o_dmem_ren | o_dmem_wen), 32'd0);
            finish_rsp(tag, 32'd0, 1'b1, cause);
            return;
        end
        for (int i = 0; i < ready_delay; i++) begin
            check_dmem(tag, wen, f3, a, wd);
            @(negedge i_clk);
        end
        check_dmem(tag, wen, f3, a, wd);
        word = mem_word(a);
        i_dmem_ready = 1'b1;
        if (rvalid_delay == 0) begin
            i_dmem_rvalid = 1'b1;
            i_dmem_rdata  = word;
        end
        @(negedge i_clk);
        i_dmem_ready  = 1'b0;
        i_dmem_rvalid = 1'b0;
        i_dmem_rdata  = $urandom;
        if (rvalid_delay > 0) begin
            for (int i = 0; i < rvalid_delay - 1; i++) begin
                check({tag, "_wait_novalid"}, 32'(o_rsp_valid), 32'd0);
                check({tag, "_wait_noren"}, 32'(o_dmem_ren | o_dmem_wen), 32'd0);
                @(negedge i_clk);
            end
            i_dmem_rvalid = 1'b1;
            i_dmem_rdata  = word;
            @(negedge i_clk);
            i_dmem_rvalid = 1'b0;
        end
        if (wen) begin
            shifted = 32'(longint'(wd) << (8 * (a % 4)));
            mask    = model_mask(f3, a);
            for (int b = 0; b < 4; b++) begin
                if (mask[b]) word[8*b +: 8] = shifted[8*b +: 8];
            end
            mem[a >> 2] = word;
            finish_rsp(tag, 32'd0, 1'b0, 2'b00);
        end else begin
            finish_rsp(tag, model_load(f3, word, a), 1'b0, 2'b00);
        end
    endtask

    initial begin
        int waits;
        int valid_seen;
        logic [2:0]  f3;
        logic [31:0] a;
        checks        = 0;
        failures      = 0;
        i_rst_n       = 1'b0;
        i_req_valid   = 1'b0;
        i_req_wen     = 1'b0;
        i_req_funct3  = 3'b000;
        i_req_addr    = '0;
        i_req_wdata   = '0;
        i_rsp_ready   = 1'b0;
        i_dmem_ready  = 1'b0;
        i_dmem_rvalid = 1'b0;
        i_dmem_rdata  = '0;

        @(negedge i_clk);
        @(negedge i_clk);
        check("reset_req_ready", 32'(o_req_ready), 32'd0);
        check("reset_rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("reset_rsp_trap", 32'(o_rsp_trap), 32'd0);
        check("reset_rsp_rdata", o_rsp_rdata, 32'd0);
        check("reset_rsp_cause", 32'(o_rsp_cause), 32'd0);
        check("reset_ren_wen", 32'(o_dmem_ren | o_dmem_wen), 32'd0);
        i_rst_n = 1'b1;
        #1;
        check("release_req_ready", 32'(o_req_ready), 32'd1);
        @(negedge i_clk);

        $display("[TB] directed accesses");
        mem[32'h1000 >> 2] = 32'h8000_0000 | ($urandom & 32'h00FF_FFFF);
        check_output("lb_1003", 1'b0, 3'd0, 32'h0000_1003, 32'd0, 0, 0);
        check_output("sh_2002", 1'b1, 3'd1, 32'h0000_2002, 32'h0000_BEEF, 0, 0);
        check_output("lw_3001", 1'b0, 3'd2, 32'h0000_3001, 32'd0, 0, 0);
        check_output("lhu_4002", 1'b0, 3'd5, 32'h0000_4002, 32'd0, 3, 1);
        check_output("ld_illegal", 1'b0, 3'd3, 32'h0000_4001, 32'd0, 0, 0);
        check_output("sb_illegal", 1'b1, 3'd4, 32'h0000_4000, 32'h1234_5678, 0, 0);
        check_output("sw_2000", 1'b1, 3'd2, 32'h0000_2000, 32'hCAFE_F00D, 1, 2);
        check_output("lh_2002", 1'b0, 3'd1, 32'h0000_2002, 32'd0, 0, 1);

        $display("[TB] wait-state behaviour");
        check("wait_req_ready", 32'(o_req_ready), 32'd1);
        apply_stimulus(1'b0, 3'd2, 32'h0000_5000, 32'd0);
        i_dmem_ready = 1'b1;
        @(negedge i_clk);
        i_dmem_ready = 1'b0;
        waits = 0;
`ifdef DMEM_LSU_TIMEOUT_EN
        while (!o_rsp_valid && waits < 50) begin
            waits++;
            @(negedge i_clk);
        end
        check("timeout_wait_cycles", 32'(waits), 32'd4);
        finish_rsp("timeout", 32'd0, 1'b1, 2'b11);
`else
        valid_seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (o_rsp_valid) valid_seen++;
            @(negedge i_clk);
        end
        check("nowait_timeout_valid", 32'(valid_seen), 32'd0);
        check("nowait_still_busy", 32'(o_req_ready), 32'd0);
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata  = mem_word(32'h0000_5000);
        @(negedge i_clk);
        i_dmem_rvalid = 1'b0;
        finish_rsp("late_rvalid", mem_word(32'h0000_5000), 1'b0, 2'b00);
`endif

        $display("[TB] reset during WAIT");
        apply_stimulus(1'b0, 3'd2, 32'h0000_6000, 32'd0);
        i_dmem_ready = 1'b1;
        @(negedge i_clk);
        i_dmem_ready = 1'b0;
        #2 i_rst_n = 1'b0;
        #1;
        check("midreset_rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("midreset_req_ready", 32'(o_req_ready), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        check("midreset_idle", 32'(o_req_ready), 32'd1);
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata  = $urandom;
        @(negedge i_clk);
        i_dmem_rvalid = 1'b0;
        check("stale_rvalid_valid", 32'(o_rsp_valid), 32'd0);
        @(negedge i_clk);
        check("stale_rvalid_idle", 32'(o_req_ready), 32'd1);
        check("stale_rvalid_valid2", 32'(o_rsp_valid), 32'd0);

        $display("[TB] randomized accesses");
        for (int n = 0; n < 60; n++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = 32'h0000_7000 + $urandom_range(0, 63);
            check_output("rand", 1'($urandom), f3, a, $urandom,
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

endmodule
